// File: rtl/keypad_pkg.sv
// keypad_pkg: key-code constants shared by the scanner, this entry block and
// the downstream compare FSM, plus the entry FSM state encoding.
package keypad_pkg;

  // Key codes delivered by the scanner on digito
  localparam logic [4:0] KEY_BKSP    = 5'hE;
  localparam logic [4:0] KEY_CLR     = 5'hF;
  localparam logic [4:0] KEY_NONE    = 5'd16;
  localparam logic [4:0] KEY_INVALID = 5'd17;
  localparam logic [4:0] KEY_DIG_MAX = 5'd9;

  // Entry FSM state encoding
  localparam int         STATE_W  = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ENTRY = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // True for the decimal digit keys 0-9
  function automatic logic is_digit(input logic [4:0] key);
    return key <= KEY_DIG_MAX;
  endfunction

endpackage

// File: rtl/keypad_code_entry_if.sv
// keypad_code_entry_if: scanner-side inputs and lock-side outputs of the
// code entry block. master = scanner/lock environment, slave = entry block.
//
// Handshake: there is no backpressure. cambio_digito and enter_sync are
// edge-qualified (a rising edge is one event, holding high adds nothing).
// code_valid, overflow and timeout are single-cycle pulses; code/n_ent are
// meaningful as the finished entry only in the cycle code_valid is high.
interface keypad_code_entry_if #(
  parameter int N_DIGITS = 4
);
  localparam int CW = 4 * N_DIGITS;
  localparam int NW = $clog2(N_DIGITS + 1);

  logic [4:0]                     digito;
  logic                           cambio_digito;
  logic                           enter_sync;
  logic [CW-1:0]                  code;
  logic [NW-1:0]                  n_ent;
  logic                           code_valid;
  logic                           busy;
  logic                           overflow;
  logic                           timeout;
  logic [keypad_pkg::STATE_W-1:0] dbg_state;

  modport master (
    output digito, cambio_digito, enter_sync,
    input  code, n_ent, code_valid, busy, overflow, timeout, dbg_state
  );

  modport slave (
    input  digito, cambio_digito, enter_sync,
    output code, n_ent, code_valid, busy, overflow, timeout, dbg_state
  );

endinterface

// File: rtl/keypad_code_entry_rise_detect.sv
// rise_detect: one-cycle pulse on a 0->1 transition of i_d. The previous
// sample resets to RESET_VAL so a level held high through reset release can
// be suppressed (RESET_VAL = 1).
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  // Remember last cycle's sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= RESET_VAL;
    else     r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/keypad_code_entry.sv
// keypad_code_entry: assembles keypad digits into a BCD code word with
// backspace/clear editing and hands the finished code to the lock FSM for
// one cycle on enter.
// Optional feature macro: KEYPAD_CODE_ENTRY_TIMEOUT_EN (inactivity timeout).
module keypad_code_entry
  import keypad_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int TIMEOUT_TICKS = 500
) (
  input  logic                 clk,
  input  logic                 rst,
  keypad_code_entry_if.slave   bus
);

  localparam int              CW    = 4 * N_DIGITS;
  localparam int              NW    = $clog2(N_DIGITS + 1);
  localparam logic [NW-1:0]   N_MAX = NW'(N_DIGITS);

  logic [STATE_W-1:0] r_state;
  logic [CW-1:0]      r_code;
  logic [NW-1:0]      r_n_ent;
  logic               r_overflow;

  logic w_key_ev;
  logic w_enter_ev;
  logic w_is_digit;
  logic w_is_bksp;
  logic w_is_clr;
  logic w_key_act;
  logic w_in_entry;
  logic w_tmo_hit;

  rise_detect #(.RESET_VAL(1'b1)) u_key_rise (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.cambio_digito),
    .o_rise (w_key_ev)
  );

  rise_detect #(.RESET_VAL(1'b1)) u_enter_rise (
    .clk    (clk),
    .rst    (rst),
    .i_d    (bus.enter_sync),
    .o_rise (w_enter_ev)
  );

  assign w_is_digit = is_digit(bus.digito);
  assign w_is_bksp  = (bus.digito == KEY_BKSP);
  assign w_is_clr   = (bus.digito == KEY_CLR);
  // A key event that does something; enter in the same cycle discards it
  assign w_key_act  = w_key_ev & ~w_enter_ev & (w_is_digit | w_is_bksp | w_is_clr);
  assign w_in_entry = (r_state == ST_ENTRY) || (r_state == ST_FULL);

`ifdef KEYPAD_CODE_ENTRY_TIMEOUT_EN
  localparam int                TW       = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_TICKS - 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_timeout;

  assign w_tmo_hit = w_in_entry && (r_tmo_cnt == TMO_LAST);

  // Idle counter: runs only mid-entry, restarts on any real activity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (!w_in_entry || w_enter_ev || w_key_act || w_tmo_hit) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  // Timeout pulse coincides with the buffer being discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_timeout <= 1'b0;
    else     r_timeout <= w_tmo_hit && !w_enter_ev && !w_key_act;
  end

  assign bus.timeout = r_timeout;
`else
  assign w_tmo_hit   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Entry FSM: buffer editing, overflow detection and hand-off on enter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_code     <= '0;
      r_n_ent    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (r_state == ST_DONE) begin
        // Finished code was presented for one cycle; start over
        r_state <= ST_IDLE;
        r_code  <= '0;
        r_n_ent <= '0;
      end else if (w_enter_ev && w_in_entry) begin
        r_state <= ST_DONE;
      end else if (w_key_act) begin
        if (w_is_digit) begin
          if (r_state == ST_FULL) begin
            r_overflow <= 1'b1;
          end else begin
            r_code  <= (r_code << 4) | CW'(bus.digito[3:0]);
            r_n_ent <= r_n_ent + NW'(1);
            r_state <= ((r_n_ent + NW'(1)) == N_MAX) ? ST_FULL : ST_ENTRY;
          end
        end else if (w_is_bksp) begin
          if (r_n_ent != '0) begin
            r_code  <= r_code >> 4;
            r_n_ent <= r_n_ent - NW'(1);
            r_state <= (r_n_ent == NW'(1)) ? ST_IDLE : ST_ENTRY;
          end
        end else begin
          r_code  <= '0;
          r_n_ent <= '0;
          r_state <= ST_IDLE;
        end
      end else if (w_tmo_hit) begin
        r_code  <= '0;
        r_n_ent <= '0;
        r_state <= ST_IDLE;
      end
    end
  end

  assign bus.code       = r_code;
  assign bus.n_ent      = r_n_ent;
  assign bus.code_valid = (r_state == ST_DONE);
  assign bus.busy       = (r_n_ent != '0) || (r_state == ST_DONE);
  assign bus.overflow   = r_overflow;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_keypad_code_entry.sv
// tb_keypad_code_entry: directed scenarios; finished codes are queued as
// {n_ent, code} when enter is issued and checked by a monitor when the DUT
// pulses code_valid.
module tb_keypad_code_entry;

  localparam int N_DIGITS      = 4;
  localparam int TIMEOUT_TICKS = 10;
  localparam int CW            = 4 * N_DIGITS;
  localparam int NW            = $clog2(N_DIGITS + 1);
  localparam int W             = NW + CW;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;
  int ov_seen;

  logic [W-1:0] exp_q[$];

  keypad_code_entry_if #(.N_DIGITS(N_DIGITS)) bus ();

  keypad_code_entry #(
    .N_DIGITS      (N_DIGITS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [4:0] k);
    bus.digito        = k;
    bus.cambio_digito = 1'b1;
    cycles(3);
    bus.cambio_digito = 1'b0;
    cycles(2);
  endtask

  task automatic press_enter();
    bus.enter_sync = 1'b1;
    cycles(2);
    bus.enter_sync = 1'b0;
    cycles(2);
  endtask

  task automatic expect_code(input logic [NW-1:0] n, input logic [CW-1:0] c);
    exp_q.push_back({n, c});
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         prev_cv;
  logic         prev_ov;
  logic         prev_to;
  logic [W-1:0] exp_item;

  initial begin
    prev_cv = 1'b0;
    prev_ov = 1'b0;
    prev_to = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_cv = 1'b0;
      prev_ov = 1'b0;
      prev_to = 1'b0;
    end else begin
      if (prev_cv) begin
        check("after_valid_code", 32'(bus.code), 32'h0);
        check("after_valid_n_ent", 32'(bus.n_ent), 32'h0);
        check("after_valid_cv_low", 32'(bus.code_valid), 32'h0);
      end
      if (bus.code_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_code_valid", 32'(bus.code), 32'hDEAD_BEEF);
        end else begin
          exp_item = exp_q.pop_front();
          check("valid_code", 32'(bus.code), 32'(exp_item[CW-1:0]));
          check("valid_n_ent", 32'(bus.n_ent), 32'(exp_item[W-1:CW]));
        end
      end
      if (bus.overflow) begin
        ov_seen++;
        if (prev_ov) check("overflow_width", 32'h2, 32'h1);
      end
      if (bus.timeout && prev_to) check("timeout_width", 32'h2, 32'h1);
      prev_cv = bus.code_valid;
      prev_ov = bus.overflow;
      prev_to = bus.timeout;
    end
  end

  // ---------------- stimulus ----------------
  int ov_before;
  int to_first;
  int to_count;

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    ov_seen           = 0;
    rst               = 1'b1;
    bus.digito        = 5'd16;
    bus.cambio_digito = 1'b0;
    bus.enter_sync    = 1'b0;
    cycles(3);
    check("reset_code", 32'(bus.code), 32'h0);
    check("reset_n_ent", 32'(bus.n_ent), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_cv", 32'(bus.code_valid), 32'h0);
    check("reset_ov", 32'(bus.overflow), 32'h0);
    check("reset_to", 32'(bus.timeout), 32'h0);
    rst = 1'b0;
    cycles(2);

    // 1,2,3 then enter
    press_key(5'd1);
    press_key(5'd2);
    press_key(5'd3);
    check("t1_code", 32'(bus.code), 32'h0123);
    check("t1_n_ent", 32'(bus.n_ent), 32'd3);
    check("t1_busy", 32'(bus.busy), 32'd1);
    expect_code(3'd3, 16'h0123);
    press_enter();
    check("t1_busy_after", 32'(bus.busy), 32'd0);

    // 1..5 into a 4-digit buffer
    ov_before = ov_seen;
    press_key(5'd1);
    press_key(5'd2);
    press_key(5'd3);
    press_key(5'd4);
    check("t2_no_ov_yet", 32'(ov_seen - ov_before), 32'd0);
    check("t2_n_ent_full", 32'(bus.n_ent), 32'd4);
    press_key(5'd5);
    check("t2_ov_once", 32'(ov_seen - ov_before), 32'd1);
    check("t2_code", 32'(bus.code), 32'h1234);
    expect_code(3'd4, 16'h1234);
    press_enter();

    // 7,8,backspace,9
    press_key(5'd7);
    press_key(5'd8);
    press_key(5'hE);
    check("t3_bksp_code", 32'(bus.code), 32'h0007);
    press_key(5'd9);
    expect_code(3'd2, 16'h0079);
    press_enter();

    // 7,8,clear,9
    press_key(5'd7);
    press_key(5'd8);
    press_key(5'hF);
    check("t3_clr_n_ent", 32'(bus.n_ent), 32'd0);
    press_key(5'd9);
    expect_code(3'd1, 16'h0009);
    press_enter();

    // key 5 and enter rising together after 1,2
    press_key(5'd1);
    press_key(5'd2);
    expect_code(3'd2, 16'h0012);
    bus.digito        = 5'd5;
    bus.cambio_digito = 1'b1;
    bus.enter_sync    = 1'b1;
    cycles(3);
    bus.cambio_digito = 1'b0;
    bus.enter_sync    = 1'b0;
    cycles(2);
    check("t4_n_ent_after", 32'(bus.n_ent), 32'd0);

    // enter in IDLE, letter key, held digit
    press_enter();
    check("t5_idle_enter_busy", 32'(bus.busy), 32'd0);
    press_key(5'hB);
    check("t5_letter_n_ent", 32'(bus.n_ent), 32'd0);
    bus.digito        = 5'd6;
    bus.cambio_digito = 1'b1;
    cycles(3);
    check("t5_held_n_ent", 32'(bus.n_ent), 32'd1);
    check("t5_held_code", 32'(bus.code), 32'h0006);
    cycles(47);
`ifdef KEYPAD_CODE_ENTRY_TIMEOUT_EN
    check("t5_held_end_n_ent", 32'(bus.n_ent), 32'd0);
`else
    check("t5_held_end_n_ent", 32'(bus.n_ent), 32'd1);
`endif
    bus.cambio_digito = 1'b0;
    cycles(2);
    press_key(5'hF);
    check("t5_cleared", 32'(bus.n_ent), 32'd0);

    // key 4 then idle
    to_first = 0;
    to_count = 0;
    bus.digito        = 5'd4;
    bus.cambio_digito = 1'b1;
    cycles(1);
    bus.cambio_digito = 1'b0;
    check("t6_key_code", 32'(bus.code), 32'h0004);
    for (int i = 1; i <= 15; i++) begin
      cycles(1);
      if (bus.timeout) begin
        to_count++;
        if (to_first == 0) to_first = i;
      end
    end
`ifdef KEYPAD_CODE_ENTRY_TIMEOUT_EN
    check("t6_to_cycle", 32'(to_first), 32'd10);
    check("t6_to_count", 32'(to_count), 32'd1);
    check("t6_code", 32'(bus.code), 32'h0);
    check("t6_busy", 32'(bus.busy), 32'd0);
`else
    check("t6_to_count", 32'(to_count), 32'd0);
    check("t6_code", 32'(bus.code), 32'h0004);
    check("t6_busy", 32'(bus.busy), 32'd1);
    press_key(5'hF);
`endif

    // reset mid-entry; key held through reset release
    press_key(5'd1);
    press_key(5'd2);
    bus.digito        = 5'd3;
    bus.cambio_digito = 1'b1;
    rst               = 1'b1;
    #1;
    check("t7_async_code", 32'(bus.code), 32'h0);
    check("t7_async_n_ent", 32'(bus.n_ent), 32'd0);
    cycles(2);
    rst = 1'b0;
    cycles(3);
    check("t7_held_through_rst", 32'(bus.n_ent), 32'd0);
    bus.cambio_digito = 1'b0;
    cycles(2);
    press_key(5'd8);
    check("t7_after_rst_code", 32'(bus.code), 32'h0008);
    expect_code(3'd1, 16'h0008);
    press_enter();

    cycles(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_code_entry.md
# keypad_code_entry

Consumes the keypad scanner's 5-bit key code, key-event strobe and synchronised enter line. Assembles up to N_DIGITS decimal digits into a BCD code word with clear and backspace editing. On enter, presents the finished code for exactly one cycle to the downstream lock/compare FSM. Runs on the same 100 Hz system clock as the scanner.

## Interface
- N_DIGITS, 4: maximum digits held; legal range 1–8.
- TIMEOUT_TICKS, 500: idle clock cycles before an unfinished entry is discarded (5 s at 100 Hz); legal range ≥2.
- clk  in  1  system clock, 100 Hz, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- digito  in  5  key code from scanner: 0–9 digits; 0xA–0xD letters; 0xE backspace; 0xF clear; 16 no key; 17 invalid.
- cambio_digito  in  1  key-event strobe from scanner; may stay high while the key is held.
- enter_sync  in  1  synchronised enter button; level.
- code  out  4*N_DIGITS  live BCD buffer; newest digit in nibble 0.
- n_ent  out  $clog2(N_DIGITS+1)  number of digits currently held.
- code_valid  out  1  one-cycle pulse; code/n_ent hold the finished entry.
- busy  out  1  high while n_ent≠0 or in DONE.
- overflow  out  1  one-cycle pulse; a digit was dropped because the buffer was full.
- timeout  out  1  one-cycle pulse; entry discarded for inactivity (0 when feature compiled out).

## Operation
- Event detection:
  - Key event = rising edge of cambio_digito (current sample 1, previous sample 0).
  - Enter event = rising edge of enter_sync.
  - A held key produces exactly one event.
- Key actions on a key event:
  - Digit 0–9: shift code left one nibble, insert digit at nibble 0, n_ent+1.
  - 0xE: shift right one nibble, zero-fill the top nibble, n_ent−1. No effect when n_ent=0.
  - 0xF: code=0, n_ent=0.
  - 0xA–0xD, 16, 17: ignored.
- States:
  - IDLE (n_ent=0): digit → ENTRY, or FULL if N_DIGITS=1. Enter ignored; no pulse.
  - ENTRY (0<n_ent<N_DIGITS): digit → ENTRY or FULL. Backspace to 0 → IDLE. Clear → IDLE. Enter → DONE.
  - FULL (n_ent=N_DIGITS): digit → dropped, code unchanged, overflow pulse. Backspace → ENTRY, or IDLE if N_DIGITS=1. Clear → IDLE. Enter → DONE.
  - DONE: code_valid=1 for this single cycle; all events ignored. Next cycle → IDLE with code=0, n_ent=0.
- Key event and enter event in the same cycle: enter wins; the key event is discarded.
- Timeout: applies in ENTRY/FULL only (see Configuration).

## Timing
- Reset values:
  - code=0, n_ent=0, code_valid=0, busy=0, overflow=0, timeout=0, state IDLE, timeout counter 0.
  - Both previous-sample registers reset to 1, so a key or enter held through reset release is not accepted.
- Latency: event-sampling edge k → updated code/n_ent/pulses visible after edge k (1 cycle from input change).
- code_valid: high in the cycle after the enter-sampling edge; clears at the following edge, where code returns to 0.
- overflow and timeout: exactly one cycle wide.
- Back-to-back key events are legal; each needs cambio_digito low for at least one sampled cycle between them.
- Reset asserted mid-entry: the buffer is lost immediately (asynchronous); no code_valid is emitted.

## Configuration
- KEYPAD_CODE_ENTRY_TIMEOUT_EN defined:
  - Counter runs in ENTRY/FULL; any accepted key or enter event reloads it to 0.
  - When the counter reaches TIMEOUT_TICKS−1, the next edge clears the buffer, pulses timeout and returns to IDLE.
- Undefined: no counter is instantiated, timeout is tied to 0, and an entry persists indefinitely.

## Structure
- Package keypad_pkg:
  - Key-code constants KEY_BKSP=5'hE, KEY_CLR=5'hF, KEY_NONE=5'd16, KEY_INVALID=5'd17.
  - State encoding IDLE/ENTRY/FULL/DONE.
  - The scanner and the downstream compare FSM reuse the key-code constants.
- One sub-module, rise_detect: previous-sample register with parameterised reset value, plus AND-NOT pulse. Instantiated twice (key event, enter event).

## Test plan
- Reset, then key 1, 2, 3 (each strobe high 3 cycles, low 2), then enter → code=16'h0123, n_ent=3, code_valid exactly 1 cycle; next cycle code=0, n_ent=0.
- Keys 1,2,3,4,5 with N_DIGITS=4 → code=16'h1234, overflow pulses once, on the 5th key; enter → code_valid with 16'h1234.
- Keys 7,8, then 0xE, then 9, then enter → code_valid with code=16'h0079, n_ent=2. Repeat with 0xF in place of 0xE → code=16'h0009, n_ent=1.
- Key 5 and enter rising in the same cycle after keys 1,2 → code_valid with 16'h0012; digit 5 not stored.
- Enter in IDLE, key 0xB, key strobe held high 50 cycles → no code_valid; n_ent=0 after 0xB; a single held digit increments n_ent by 1 only.
- With KEYPAD_CODE_ENTRY_TIMEOUT_EN and TIMEOUT_TICKS=10: key 4, then idle → timeout pulses on the 10th cycle after the key, code=0, busy=0. Without the macro: the same stimulus leaves code=16'h0004 indefinitely.
